// File: rtl/cs_round_robin_arbiter.sv
// cs_round_robin_arbiter
//   Round-robin arbiter granting one shared bus to four requesters. Drives
//   active-low one-hot chip selects (74x139 style), the encoded select pair
//   and an active-low enable. Each grant is bounded by a hold timer and is
//   always followed by one dead cycle so two selects never overlap.
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset
//   REQ      in   [3:0] level request, bit i = requester i
//   DONE     in   [3:0] release pulse, only the current grantee's bit counts
//   Y        out  [3:0] active-low one-hot grant, 4'b1111 when idle
//   G_L      out  active-low enable, low exactly when Y has a low bit
//   SEL      out  [1:0] encoded grantee {B,A}, holds outside a grant
//   BUSY     out  high in GRANT and RECOVER
//   TIMEOUT  out  one-cycle pulse in the RECOVER cycle after a forced release
//
// state   | meaning
// IDLE    | no grant; pick next requester in rotating order from LAST+1
// GRANT   | Y/G_L asserted for SEL; hold timer running
// RECOVER | one dead cycle, all selects high, REQ ignored

module cs_round_robin_arbiter #(
   parameter int CNT_W    = 4,
   parameter int HOLD_MAX = 15
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] REQ,
   input  logic [3:0] DONE,
   output logic [3:0] Y,
   output logic       G_L,
   output logic [1:0] SEL,
   output logic       BUSY,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GRANT   = 2'b01,
      ST_RECOVER = 2'b10
   } state_t;

   // Hold timer is a down-counter: loaded with HOLD_MAX-1 at grant start and
   // terminal count at zero, so a forced release lands after HOLD_MAX cycles.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic [1:0]       win_idx;
   logic             win_vld;
   logic [1:0]       cand;
   logic             rel_norm;
   logic             rel_tc;

   // First set request searching LAST+1, LAST+2, LAST+3, LAST (mod 4).
   always_comb begin
      win_idx = 2'b00;
      win_vld = 1'b0;
      cand    = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!win_vld && REQ[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // A requester-driven release wins over the timer in the same cycle.
   assign rel_norm = DONE[sel_q] | ~REQ[sel_q];
   assign rel_tc   = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               sel_d   = win_idx;
               last_d  = win_idx;
               cnt_d   = HOLD_LOAD;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (rel_norm || rel_tc) begin
               state_d   = ST_RECOVER;
               timeout_d = ~rel_norm & rel_tc;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         sel_q     <= 2'b00;
         last_q    <= 2'b11;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Outputs decode only registered state; no path from REQ/DONE.
   always_comb begin
      Y = 4'b1111;
      if (state_q == ST_GRANT) begin
         Y = ~(4'b0001 << sel_q);
      end
   end

   assign G_L     = (state_q != ST_GRANT);
   assign SEL     = sel_q;
   assign BUSY    = (state_q != ST_IDLE);
   assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_cs_round_robin_arbiter.sv
module tb_cs_round_robin_arbiter;

   localparam int CNT_W    = 4;
   localparam int HOLD_MAX = 4;

   logic       CLK;
   logic       RESET;
   logic [3:0] REQ;
   logic [3:0] DONE;
   logic [3:0] Y;
   logic       G_L;
   logic [1:0] SEL;
   logic       BUSY;
   logic       TIMEOUT;

   int total;
   int bad;

   cs_round_robin_arbiter #(
      .CNT_W    (CNT_W),
      .HOLD_MAX (HOLD_MAX)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .REQ     (REQ),
      .DONE    (DONE),
      .Y       (Y),
      .G_L     (G_L),
      .SEL     (SEL),
      .BUSY    (BUSY),
      .TIMEOUT (TIMEOUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Compares {Y, G_L, SEL, BUSY, TIMEOUT} against hand-computed values.
   task automatic check(input string tag, input logic [3:0] y_e, input logic gl_e,
                        input logic [1:0] sel_e, input logic busy_e, input logic to_e);
      logic [8:0] obs;
      logic [8:0] exp_v;
      obs   = {Y, G_L, SEL, BUSY, TIMEOUT};
      exp_v = {y_e, gl_e, sel_e, busy_e, to_e};
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s: observed Y/GL/SEL/BUSY/TO=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                tag, obs[8:5], obs[4], obs[3:2], obs[1], obs[0],
                exp_v[8:5], exp_v[4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
   endtask

   initial begin
      logic [3:0] y_g;
      logic [1:0] s_g;
      total = 0;
      bad   = 0;
      RESET = 1'b1;
      REQ   = 4'b1111;
      DONE  = 4'b0000;

      // reset held two cycles with all requesting
      step();
      check("rst_c1", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);
      step();
      check("rst_c2", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);
      RESET = 1'b0;
      step();
      check("first_grant_r0", 4'b1110, 1'b0, 2'b00, 1'b1, 1'b0);
      REQ = 4'b0000;
      step();
      check("r0_recover", 4'b1111, 1'b1, 2'b00, 1'b1, 1'b0);
      step();
      check("r0_idle", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);

      // single requester 2, DONE on 3rd grant cycle
      REQ = 4'b0100;
      step();
      check("single_c1", 4'b1011, 1'b0, 2'b10, 1'b1, 1'b0);
      step();
      check("single_c2", 4'b1011, 1'b0, 2'b10, 1'b1, 1'b0);
      step();
      check("single_c3", 4'b1011, 1'b0, 2'b10, 1'b1, 1'b0);
      DONE = 4'b0100;
      step();
      DONE = 4'b0000;
      REQ  = 4'b0000;
      check("single_recover", 4'b1111, 1'b1, 2'b10, 1'b1, 1'b0);
      step();
      check("single_idle", 4'b1111, 1'b1, 2'b10, 1'b0, 1'b0);

      // reset back to LAST=3 for the rotation test
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("rst2", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);

      // round robin 0,1,2,3 with DONE on 2nd grant cycle
      REQ = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         s_g = 2'(g);
         y_g = ~(4'b0001 << g);
         step();
         check($sformatf("rr%0d_c1", g), y_g, 1'b0, s_g, 1'b1, 1'b0);
         step();
         check($sformatf("rr%0d_c2", g), y_g, 1'b0, s_g, 1'b1, 1'b0);
         DONE = y_g ^ 4'b1111;
         step();
         DONE = 4'b0000;
         check($sformatf("rr%0d_gap1", g), 4'b1111, 1'b1, s_g, 1'b1, 1'b0);
         step();
         check($sformatf("rr%0d_gap2", g), 4'b1111, 1'b1, s_g, 1'b0, 1'b0);
      end

      // fifth grant wraps to 0; foreign DONE ignored, then drop REQ[0]
      step();
      check("rr4_c1", 4'b1110, 1'b0, 2'b00, 1'b1, 1'b0);
      DONE = 4'b0010;
      step();
      check("foreign_done_ignored", 4'b1110, 1'b0, 2'b00, 1'b1, 1'b0);
      DONE = 4'b0000;
      REQ  = 4'b1110;
      step();
      check("req_drop_recover", 4'b1111, 1'b1, 2'b00, 1'b1, 1'b0);

      // timeout: requester 1 held HOLD_MAX cycles with no DONE
      REQ = 4'b1010;
      step();
      check("to_idle", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);
      for (int c = 1; c <= HOLD_MAX; c++) begin
         step();
         check($sformatf("to_grant_c%0d", c), 4'b1101, 1'b0, 2'b01, 1'b1, 1'b0);
      end
      step();
      check("to_pulse", 4'b1111, 1'b1, 2'b01, 1'b1, 1'b1);
      step();
      check("to_pulse_end", 4'b1111, 1'b1, 2'b01, 1'b0, 1'b0);
      step();
      check("after_to_r3", 4'b0111, 1'b0, 2'b11, 1'b1, 1'b0);

      // DONE coincident with terminal count is a normal release
      step();
      step();
      step();
      check("tc_c4", 4'b0111, 1'b0, 2'b11, 1'b1, 1'b0);
      DONE = 4'b1000;
      step();
      DONE = 4'b0000;
      REQ  = 4'b0100;
      check("tc_done_no_to", 4'b1111, 1'b1, 2'b11, 1'b1, 1'b0);
      step();
      check("tc_idle", 4'b1111, 1'b1, 2'b11, 1'b0, 1'b0);

      // reset during a grant to requester 2
      step();
      check("mid_grant_r2", 4'b1011, 1'b0, 2'b10, 1'b1, 1'b0);
      RESET = 1'b1;
      REQ   = 4'b1111;
      step();
      RESET = 1'b0;
      check("mid_rst", 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0);
      step();
      check("post_rst_r0", 4'b1110, 1'b0, 2'b00, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
